// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: FSM state encoding,
// ALU function select codes and sequencer-level opcodes.
package alu_op_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [2:0] FUN_PASS_A = 3'b000;
    localparam logic [2:0] FUN_SUB    = 3'b001;
    localparam logic [2:0] FUN_PASS_B = 3'b010;
    localparam logic [2:0] FUN_ADD    = 3'b011;
    localparam logic [2:0] FUN_NOR    = 3'b100;

    localparam logic [3:0] OP_LOADI = 4'b1000;
    localparam logic [3:0] OP_CLRF  = 4'b1001;

    // Opcodes 0xxx drive the ALU; of the 1xxx space only LOADI and CLRF exist.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op[3] == 1'b0) || (op == OP_LOADI) || (op == OP_CLRF);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    // Count enabled increments, sticking at the maximum value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer in front of the 4-bit ALU. Accepts one command per
// handshake, runs it through IDLE -> EXEC -> DONE, and writes the ALU result
// (or an immediate) back into the accumulator and carry/zero flags.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [3:0]         cmd_op,
    input  logic [3:0]         cmd_imm,
    output logic               cmd_ready,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [2:0]         alu_fun,
    input  logic [4:0]         alu_y,
    output logic [3:0]         acc,
    output logic               flag_c,
    output logic               flag_z,
    output logic               done,
    output logic               err,
    output logic [COUNT_W-1:0] op_count
);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] op_r;
    logic [3:0] imm_r;
    logic       exec_legal;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE ignores cmd_valid and always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_valid) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only, so no input-to-output path.
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        done      = (state == ST_DONE);
        err       = (state == ST_DONE) && !op_is_legal(op_r);
    end

    // ALU operands come straight from registers, so they are stable through EXEC.
    always_comb begin
        alu_a   = acc;
        alu_b   = imm_r;
        alu_fun = op_r[2:0];
    end

    // Capture the command on the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r  <= 4'd0;
            imm_r <= 4'd0;
        end else if (state == ST_IDLE && cmd_valid) begin
            op_r  <= cmd_op;
            imm_r <= cmd_imm;
        end
    end

    // Write-back at the EXEC->DONE edge; illegal opcodes leave state untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= 4'd0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (state == ST_EXEC) begin
            if (op_r[3] == 1'b0) begin
                acc    <= alu_y[3:0];
                flag_c <= alu_y[4];
                flag_z <= (alu_y[3:0] == 4'd0);
            end else if (op_r == OP_LOADI) begin
                acc    <= imm_r;
                flag_c <= 1'b0;
                flag_z <= (imm_r == 4'd0);
            end else if (op_r == OP_CLRF) begin
                flag_c <= 1'b0;
                flag_z <= 1'b0;
            end
        end
    end

    assign exec_legal = (state == ST_EXEC) && op_is_legal(op_r);

    sat_counter #(
        .COUNT_W (COUNT_W)
    ) u_op_count (
        .clk   (clk),
        .reset (reset),
        .inc   (exec_legal),
        .count (op_count)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [3:0] cmd_op;
    logic [3:0] cmd_imm;
    logic       cmd_ready;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_fun;
    logic [4:0] alu_y;
    logic [3:0] acc;
    logic       flag_c;
    logic       flag_z;
    logic       done;
    logic       err;
    logic [7:0] op_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.COUNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_imm   (cmd_imm),
        .cmd_ready (cmd_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fun   (alu_fun),
        .alu_y     (alu_y),
        .acc       (acc),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .done      (done),
        .err       (err),
        .op_count  (op_count)
    );

    // Lab ALU model: 5-bit result, bit 4 is carry/borrow.
    always_comb begin
        case (alu_fun)
            3'b000:  alu_y = {1'b0, alu_a};
            3'b001:  alu_y = {1'b0, alu_a} - {1'b0, alu_b};
            3'b010:  alu_y = {1'b0, alu_b};
            3'b011:  alu_y = {1'b0, alu_a} + {1'b0, alu_b};
            3'b100:  alu_y = {1'b0, ~(alu_a | alu_b)};
            default: alu_y = 5'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full command with checks at every phase; caller is #1 after an edge in IDLE.
    task automatic do_cmd(input string tag, input logic [3:0] op, input logic [3:0] imm,
                          input logic [3:0] e_acc, input logic e_c, input logic e_z,
                          input logic [7:0] e_cnt, input logic e_err);
        chk({tag, ".ready_idle"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        step();
        cmd_valid = 1'b0;
        chk({tag, ".exec_ready"}, cmd_ready, 1'b0);
        chk({tag, ".exec_done"}, done, 1'b0);
        chk({tag, ".exec_fun"}, alu_fun, op[2:0]);
        chk({tag, ".exec_b"}, alu_b, imm);
        step();
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".err"}, err, e_err);
        chk({tag, ".done_ready"}, cmd_ready, 1'b0);
        chk({tag, ".acc"}, acc, e_acc);
        chk({tag, ".c"}, flag_c, e_c);
        chk({tag, ".z"}, flag_z, e_z);
        chk({tag, ".cnt"}, op_count, e_cnt);
        step();
        chk({tag, ".done_low"}, done, 1'b0);
        chk({tag, ".err_low"}, err, 1'b0);
        chk({tag, ".ready_back"}, cmd_ready, 1'b1);
    endtask

    task automatic quiet_cmd(input logic [3:0] op, input logic [3:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_imm   = imm;
        step();
        cmd_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_imm   = 4'd0;
        step();
        step();
        chk("rst.acc", acc, 4'd0);
        chk("rst.c", flag_c, 1'b0);
        chk("rst.z", flag_z, 1'b0);
        chk("rst.cnt", op_count, 8'd0);
        chk("rst.ready", cmd_ready, 1'b1);
        chk("rst.fun", alu_fun, 3'b000);
        chk("rst.b", alu_b, 4'd0);
        chk("rst.done", done, 1'b0);
        chk("rst.err", err, 1'b0);
        reset = 1'b0;
        step();

        do_cmd("loadi9",   4'b1000, 4'd9, 4'd9,  1'b0, 1'b0, 8'd1, 1'b0);
        do_cmd("add9",     4'b0011, 4'd9, 4'd2,  1'b1, 1'b0, 8'd2, 1'b0);
        do_cmd("sub2",     4'b0001, 4'd2, 4'd0,  1'b0, 1'b1, 8'd3, 1'b0);
        do_cmd("sub1",     4'b0001, 4'd1, 4'hF,  1'b1, 1'b0, 8'd4, 1'b0);
        do_cmd("illegal",  4'b1100, 4'd3, 4'hF,  1'b1, 1'b0, 8'd4, 1'b1);
        do_cmd("clrf",     4'b1001, 4'd7, 4'hF,  1'b0, 1'b0, 8'd5, 1'b0);
        do_cmd("nor",      4'b0100, 4'd0, 4'd0,  1'b0, 1'b1, 8'd6, 1'b0);
        do_cmd("fun101",   4'b0101, 4'd6, 4'd0,  1'b0, 1'b1, 8'd7, 1'b0);
        do_cmd("loadi5",   4'b1000, 4'd5, 4'd5,  1'b0, 1'b0, 8'd8, 1'b0);
        do_cmd("passb",    4'b0010, 4'd6, 4'd6,  1'b0, 1'b0, 8'd9, 1'b0);
        do_cmd("passa",    4'b0000, 4'd3, 4'd6,  1'b0, 1'b0, 8'd10, 1'b0);
        do_cmd("loadi0",   4'b1000, 4'd0, 4'd0,  1'b0, 1'b1, 8'd11, 1'b0);
        do_cmd("illegal2", 4'b1111, 4'd1, 4'd0,  1'b0, 1'b1, 8'd11, 1'b1);

        // cmd_valid held high: accepted only every third cycle.
        cmd_valid = 1'b1;
        cmd_op    = 4'b1000;
        cmd_imm   = 4'd3;
        for (int i = 0; i < 9; i++) begin
            chk("hold.ready", cmd_ready, (i % 3 == 0) ? 1'b1 : 1'b0);
            chk("hold.done", done, (i % 3 == 2) ? 1'b1 : 1'b0);
            step();
        end
        cmd_valid = 1'b0;
        chk("hold.cnt", op_count, 8'd14);
        chk("hold.acc", acc, 4'd3);

        // Reset while in EXEC: pending write and done are dropped.
        cmd_valid = 1'b1;
        cmd_op    = 4'b1000;
        cmd_imm   = 4'd7;
        step();
        cmd_valid = 1'b0;
        chk("rexec.in_exec", cmd_ready, 1'b0);
        reset = 1'b1;
        step();
        chk("rexec.done", done, 1'b0);
        chk("rexec.acc", acc, 4'd0);
        chk("rexec.ready", cmd_ready, 1'b1);
        chk("rexec.cnt", op_count, 8'd0);
        reset = 1'b0;
        step();
        chk("rexec.done2", done, 1'b0);
        chk("rexec.acc2", acc, 4'd0);

        // Reset wins over a simultaneous handshake.
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 4'b1000;
        cmd_imm   = 4'd4;
        step();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        chk("rprio.ready", cmd_ready, 1'b1);
        step();
        chk("rprio.done", done, 1'b0);
        chk("rprio.acc", acc, 4'd0);
        chk("rprio.cnt", op_count, 8'd0);

        // Drive the counter to its ceiling, then one more command.
        for (int i = 0; i < 255; i++) begin
            quiet_cmd(4'b1000, 4'd1);
        end
        chk("sat.pre", op_count, 8'd255);
        do_cmd("sat", 4'b1000, 4'd2, 4'd2, 1'b0, 1'b0, 8'd255, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
